// File: rtl/uart_tx_if.sv
// uart_tx parallel-side handshake bundle.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: baud-tick driven serial transmitter, LSB first.
// Frame is start, DATA_BITS data, optional parity, STOP_BITS stop.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     baud_tick,
  uart_tx_if.slave bus,
  output logic     txd,
  output logic     tx_busy,
  output logic     tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam bit         ODD_PAR   = (PARITY == 2);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;

  assign bus.tx_ready = (state == IDLE);
  assign tx_busy      = (state != IDLE);

  // Frame sequencer; every line change is registered on a baud tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (bus.tx_valid) begin
            shreg   <= bus.tx_data;
            par_bit <= (^bus.tx_data) ^ ODD_PAR;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          txd <= 1'b1;
          if (baud_tick) begin
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == BIT_LAST) begin
              if (HAS_PAR) begin
                txd   <= par_bit;
                state <= PAR;
              end else begin
                txd      <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (baud_tick) begin
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
